// File: rtl/icache_pkg.sv
// Shared types and width helpers for the I-cache data array.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DONE} refill_state_t;

  function automatic int unsigned offset_w(int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // A single-way build still needs a 1-bit way select port.
  function automatic int unsigned way_w(int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  localparam int unsigned OFFSET_W = offset_w(8);
  localparam int unsigned WAY_W    = way_w(2);

endpackage

// File: rtl/icache_way_ram.sv
// One cache way: synchronous write port plus registered read port addressed by {set, offset}.
// ICACHE_REFILL_BYPASS_EN forwards a same-address write into the read register.
module icache_way_ram
  import icache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = mem[raddr];
`ifdef ICACHE_REFILL_BYPASS_EN
    if (we && (waddr == raddr)) begin
      rdata_d = wdata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/icache_data_array.sv
// N-way I-cache data store with registered reads and a line-refill sequencer.
// Optional same-cycle refill-to-read forwarding via ICACHE_REFILL_BYPASS_EN.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SET_BITS   = 7,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rd_en,
  input  logic [SET_BITS-1:0]           rd_set,
  input  logic [offset_w(LINE_WORDS)-1:0] rd_offset,
  output logic [WAYS*DATA_WIDTH-1:0]    rd_data,
  output logic                          rd_valid,
  input  logic                          refill_start,
  input  logic [SET_BITS-1:0]           refill_set,
  input  logic [way_w(WAYS)-1:0]        refill_way,
  input  logic                          refill_valid,
  input  logic [DATA_WIDTH-1:0]         refill_data,
  output logic                          refill_ready,
  output logic                          refill_done,
  output logic                          busy
);

  localparam int unsigned OffW  = offset_w(LINE_WORDS);
  localparam int unsigned WayW  = way_w(WAYS);
  localparam int unsigned AddrW = SET_BITS + OffW;

  refill_state_t state_q, state_d;
  logic [OffW-1:0]     cnt_q, cnt_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic [WayW-1:0]     way_q, way_d;
  logic                rd_valid_q;
  logic                accept;
  logic                last_word;

  // Gate with reset so a word arriving during reset never lands in the array.
  assign accept    = refill_valid && refill_ready && resetn;
  assign last_word = (cnt_q == OffW'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      set_q      <= '0;
      way_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      set_q      <= set_d;
      way_q      <= way_d;
      rd_valid_q <= rd_en;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    set_d        = set_q;
    way_d        = way_q;
    refill_ready = 1'b0;
    refill_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (refill_start) begin
          set_d   = refill_set;
          way_d   = refill_way;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        refill_ready = 1'b1;
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        refill_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign rd_valid = rd_valid_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic we;
    assign we = accept && (way_q == WayW'(w));

    icache_way_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (AddrW)
    ) u_ram (
      .clk    (clk),
      .resetn (resetn),
      .we     (we),
      .waddr  ({set_q, cnt_q}),
      .wdata  (refill_data),
      .re     (rd_en),
      .raddr  ({rd_set, rd_offset}),
      .rdata  (rd_data[w*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_icache_data_array.sv
// Scoreboard bench for icache_data_array; honours ICACHE_REFILL_BYPASS_EN for expectations.
module tb_icache_data_array;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rd_en;
  logic [6:0]  rd_set;
  logic [2:0]  rd_offset;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        refill_start;
  logic [6:0]  refill_set;
  logic [0:0]  refill_way;
  logic        refill_valid;
  logic [31:0] refill_data;
  logic        refill_ready;
  logic        refill_done;
  logic        busy;

  int n_checks = 0;
  int n_bad    = 0;

  logic [31:0] model [2][128][8];
  logic [63:0] exp_q [$];
  logic [63:0] last_exp = '0;

  always #5 clk = ~clk;

  icache_data_array u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .rd_en        (rd_en),
    .rd_set       (rd_set),
    .rd_offset    (rd_offset),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .refill_start (refill_start),
    .refill_set   (refill_set),
    .refill_way   (refill_way),
    .refill_valid (refill_valid),
    .refill_data  (refill_data),
    .refill_ready (refill_ready),
    .refill_done  (refill_done),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Read results arrive one cycle after the request.
  always @(posedge clk) begin
    #1;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 64'd1, 64'd0);
      end else begin
        last_exp = exp_q.pop_front();
        check("rd_data", rd_data, last_exp);
      end
    end
  end

  function automatic logic [63:0] line_word(input int set, input int off);
    return {model[1][set][off], model[0][set][off]};
  endfunction

  task automatic read_line(input int set);
    for (int off = 0; off < 8; off++) begin
      @(negedge clk);
      rd_en = 1'b1; rd_set = 7'(set); rd_offset = 3'(off);
      exp_q.push_back(line_word(set, off));
    end
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    check("rd_valid_low", {63'd0, rd_valid}, 64'd0);
    check("rd_hold", rd_data, last_exp);
  endtask

  // poke: stray start toward set 9 mid-fill. abcd: word 3 is 0xABCD, read alongside every word.
  task automatic refill(input int set, input int way, input logic [31:0] base,
                        input bit gaps, input bit poke, input bit abcd);
    int n = 0;
    int cyc;
    logic [31:0] w;
    @(negedge clk);
    refill_start = 1'b1; refill_set = 7'(set); refill_way = 1'(way);
    @(negedge clk);
    refill_start = 1'b0;
    cyc = 1;
    while (n < 8 && cyc < 40) begin
      check("ready_fill", {63'd0, refill_ready}, 64'd1);
      check("no_early_done", {63'd0, refill_done}, 64'd0);
      refill_start = poke && (n == 2);
      if (poke && n == 2) refill_set = 7'd9;
      rd_en = 1'b0;
      if (!gaps || cyc[0]) begin
        w = (abcd && n == 3) ? 32'hABCD : base + 32'(n);
        if (abcd) begin
          rd_en = 1'b1;
          if (n == 3) begin
            rd_set = 7'(set); rd_offset = 3'd3;
`ifdef ICACHE_REFILL_BYPASS_EN
            exp_q.push_back(way == 1 ? {w, model[0][set][3]} : {model[1][set][3], w});
`else
            exp_q.push_back(line_word(set, 3));
`endif
          end else begin
            rd_set = 7'd9; rd_offset = 3'(n);
            exp_q.push_back(line_word(9, n));
          end
        end
        refill_valid = 1'b1; refill_data = w;
        model[way][set][n] = w;
        n++;
      end else begin
        refill_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    refill_valid = 1'b0; refill_start = 1'b0; rd_en = 1'b0;
    check("done_pulse", {63'd0, refill_done}, 64'd1);
    check("busy_in_done", {63'd0, busy}, 64'd1);
    check("done_latency", 64'(cyc), gaps ? 64'd16 : 64'd9);
    @(negedge clk);
    check("done_one_cycle", {63'd0, refill_done}, 64'd0);
    check("ready_idle", {63'd0, refill_ready}, 64'd0);
    check("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    resetn = 1'b0; rd_en = 1'b1; rd_set = '0; rd_offset = '0;
    refill_start = 1'b0; refill_set = '0; refill_way = '0;
    refill_valid = 1'b1; refill_data = 32'hDEAD;
    repeat (3) @(negedge clk);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_ready", {63'd0, refill_ready}, 64'd0);
    check("rst_done", {63'd0, refill_done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rd_en = 1'b0; refill_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_rd_valid", {63'd0, rd_valid}, 64'd0);

    refill(5, 0, 32'h200, 1'b0, 1'b0, 1'b0);
    refill(5, 1, 32'h100, 1'b0, 1'b0, 1'b0);
    read_line(5);

    refill(9, 1, 32'h900, 1'b0, 1'b0, 1'b0);
    refill(9, 0, 32'h980, 1'b0, 1'b0, 1'b0);
    refill(7, 0, 32'h700, 1'b1, 1'b0, 1'b0);
    read_line(7);

    refill(6, 1, 32'h600, 1'b0, 1'b1, 1'b0);
    read_line(6);
    read_line(9);

    refill(5, 1, 32'h500, 1'b0, 1'b0, 1'b1);
    read_line(5);

    // Abort a refill of set 2 after three words.
    @(negedge clk);
    refill_start = 1'b1; refill_set = 7'd2; refill_way = 1'b0;
    @(negedge clk);
    refill_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      refill_valid = 1'b1; refill_data = 32'hBAD0 + 32'(i);
      @(negedge clk);
    end
    refill_valid = 1'b0;
    check("busy_mid", {63'd0, busy}, 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("busy_after_rst", {63'd0, busy}, 64'd0);
    check("ready_after_rst", {63'd0, refill_ready}, 64'd0);
    resetn = 1'b1;
    refill(2, 0, 32'h220, 1'b0, 1'b0, 1'b0);
    refill(2, 1, 32'h2A0, 1'b0, 1'b0, 1'b0);
    read_line(2);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_data_array.md
# icache_data_array

Parametrised, N-way set-associative instruction-cache data store with a built-in line-refill sequencer. Replaces the single-way, combinational-read line RAM with a registered-read array holding `WAYS` ways of `2**SET_BITS` lines of `LINE_WORDS` words each. Sits between the I-cache tag/hit logic, which consumes all ways' read data one cycle after the request, and the bus interface, which streams refill words in line order.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width in bits
- `WAYS`, 2, associativity (1..8)
- `SET_BITS`, 7, log2 of sets per way
- `LINE_WORDS`, 8, words per line (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  synchronous, active-low reset
- `rd_en`  in  1  read request this cycle
- `rd_set`  in  SET_BITS  set index
- `rd_offset`  in  $clog2(LINE_WORDS)  word offset in line
- `rd_data`  out  WAYS*DATA_WIDTH  word from every way, way 0 in LSBs
- `rd_valid`  out  1  `rd_data` valid
- `refill_start`  in  1  begin line refill
- `refill_set`  in  SET_BITS  target set
- `refill_way`  in  $clog2(WAYS) (min 1)  target way
- `refill_valid`  in  1  refill word present
- `refill_data`  in  DATA_WIDTH  refill word
- `refill_ready`  out  1  block accepts refill word
- `refill_done`  out  1  one-cycle pulse, line complete
- `busy`  out  1  refill in progress

## Operation
- Reads: registered; request in cycle N → `rd_data`/`rd_valid` in N+1. `rd_data` holds last value when `rd_en`=0; `rd_valid` deasserts.
- FSM states: IDLE, FILL, DONE.
  - IDLE: `refill_start`=1 latches set/way, clears word counter, → FILL.
  - FILL: `refill_ready`=1. Word written at (set, way, counter) on `refill_valid && refill_ready`; counter increments. Acceptance of word `LINE_WORDS-1` → DONE.
  - DONE: `refill_done`=1 for one cycle → IDLE.
- `refill_start` in FILL or DONE: ignored; latched set/way unchanged.
- Counter width `$clog2(LINE_WORDS)`; wraps to 0 only on the final accept; never exceeds `LINE_WORDS-1`.
- `refill_valid` without `refill_ready` (IDLE/DONE): data dropped, no write.
- Read and refill write in the same cycle to a different line: both proceed.
- Same set/way/offset: read returns old content (read-before-write), unless bypass is enabled.
- `busy` = state != IDLE.
- Reset mid-refill: FSM → IDLE, counter → 0, partial line contents undefined. Tag logic must not validate that line.
- Array contents not reset.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `refill_ready`=0, `refill_done`=0, `busy`=0.
- Read latency: 1 cycle; one new read per cycle.
- Refill throughput: 1 word/cycle.
- Minimum refill: start cycle, then `LINE_WORDS` FILL cycles, then 1 DONE cycle. `refill_done` is high `LINE_WORDS+1` cycles after `refill_start` at full rate.
- `refill_ready` rises the cycle after `refill_start` and falls the cycle after the last accept.
- Next `refill_start` accepted in the cycle after DONE (IDLE).

## Configuration
- `ICACHE_REFILL_BYPASS_EN` defined:
  - A read whose set/way/offset matches a refill word accepted in the same cycle returns the refill word in that way's slice of `rd_data`.
  - Adds a forward mux per way.
- Undefined: read-before-write behaviour as above; no forwarding logic.

## Structure
- Package `icache_pkg`: state enum `refill_state_t` {IDLE, FILL, DONE}; derived widths `OFFSET_W`, `WAY_W`.
- Sub-module `icache_way_ram`: one way; one synchronous write port and one registered read port, depth `2**SET_BITS * LINE_WORDS`, address = {set, offset}.
  - Top instantiates `WAYS` copies; decodes `refill_way` to per-way write enables.
  - Top holds the FSM and counter.

## Test plan
- Reset, then idle → all outputs 0; `rd_en`=1 leaves `rd_valid`=0 until cycle after reset release.
- Refill set 5 way 1 with words 0x100..0x107 at full rate → `refill_done` 9 cycles after start; reads of set 5, offsets 0..7 return 0x100..0x107 in way-1 slice; way-0 slice unchanged.
- Refill with `refill_valid` gaps (every other cycle) → 8 writes only, `refill_ready` stays 1, `refill_done` after 8th accept.
- `refill_start` pulsed mid-FILL with set 9 → ignored; data lands in original set; set 9 untouched.
- Read set 5 way 1 offset 3 in the same cycle as refill writes 0xABCD there:
  - With macro undefined → old value returned.
  - With `ICACHE_REFILL_BYPASS_EN` → 0xABCD returned.
- `resetn`=0 after 3 refill words → `busy`=0 next cycle; new refill of set 2 then completes normally.
